// File: rtl/t04_mem_bridge.sv
// ============================================================================
// Module      : t04_mem_bridge
// Description : Bounds-checked bridge from a CPU request port to a one-strobe
//               wishbone manager, with timeout and saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t04_mem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] mem_adr_start,
    input  logic [31:0] memory_size,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_adr_err,
    output logic        mgr_read,
    output logic        mgr_write,
    output logic [31:0] mgr_adr,
    output logic [31:0] mgr_wdata,
    output logic [3:0]  mgr_sel,
    input  logic [31:0] mgr_rdata,
    input  logic        mgr_busy,
    output logic [7:0]  err_count
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             dir_wr_q;
    logic [31:0]      adr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       sel_q;
    logic [31:0]      rdata_q;
    logic [7:0]       err_cnt_q;
    logic             seen_busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic             w_latch;
    logic             w_legal;
    logic             w_mgr_finished;
    logic             w_mgr_fast;
    logic             w_timeout;
    logic [32:0]      w_end;

    // 33-bit sum so an offset near 2^32 cannot wrap into a legal range.
    assign w_end   = {1'b0, cpu_adr} + 33'd4;
    assign w_legal = (w_end <= {1'b0, memory_size});

    // A manager that completes inside the ISSUE cycle never shows busy, so a
    // full idle WAIT cycle without seen_busy also counts as completion.
    assign w_mgr_finished = seen_busy_q && !mgr_busy;
    assign w_mgr_fast     = !seen_busy_q && !mgr_busy;
    assign w_timeout      = mgr_busy && (cnt_q == C_CNT_LAST);

    always_comb begin
        state_d = state_q;
        w_latch = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (cpu_read && cpu_write) begin
                        state_d = S_ERR;
                    end else if (cpu_read || cpu_write) begin
                        w_latch = 1'b1;
                        state_d = w_legal ? S_ISSUE : S_ERR;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (w_timeout) begin
                    state_d = S_ERR;
                end else if (w_mgr_finished || w_mgr_fast) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_busy = 1'b1;
        if (!rst) begin
            case (state_q)
                S_IDLE:  cpu_busy = !en || cpu_read || cpu_write;
                S_ISSUE: cpu_busy = 1'b1;
                S_WAIT:  cpu_busy = 1'b1;
                // Completion must stay visible even if en drops mid-transfer.
                S_DONE:  cpu_busy = 1'b0;
                S_ERR:   cpu_busy = 1'b0;
                default: cpu_busy = 1'b1;
            endcase
        end
    end

    assign mgr_read    = (state_q == S_ISSUE) && !dir_wr_q;
    assign mgr_write   = (state_q == S_ISSUE) &&  dir_wr_q;
    assign cpu_adr_err = (state_q == S_ERR);
    assign mgr_adr     = adr_q;
    assign mgr_wdata   = wdata_q;
    assign mgr_sel     = sel_q;
    assign cpu_rdata   = rdata_q;
    assign err_count   = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dir_wr_q    <= 1'b0;
            adr_q       <= 32'd0;
            wdata_q     <= 32'd0;
            sel_q       <= 4'd0;
            rdata_q     <= 32'd0;
            err_cnt_q   <= 8'd0;
            seen_busy_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;

            if (w_latch) begin
                dir_wr_q <= cpu_write;
                adr_q    <= cpu_adr + mem_adr_start;
                wdata_q  <= cpu_wdata;
                sel_q    <= cpu_sel;
            end

            if (state_q == S_ISSUE) begin
                seen_busy_q <= 1'b0;
                cnt_q       <= '0;
            end else if (state_q == S_WAIT) begin
                if (mgr_busy) begin
                    seen_busy_q <= 1'b1;
                end
                if (cnt_q != C_CNT_LAST) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            if ((state_q == S_WAIT) && (state_d == S_DONE) && !dir_wr_q) begin
                rdata_q <= mgr_rdata;
            end

            if ((state_q == S_ERR) && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_t04_mem_bridge.sv
// ============================================================================
// Module      : tb_t04_mem_bridge
// Description : Directed scoreboard bench for t04_mem_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t04_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] mem_adr_start = 32'h3300_0000;
    logic [31:0] memory_size = 32'h0000_0400;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_adr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [3:0]  cpu_sel = 4'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_adr_err;
    logic        mgr_read;
    logic        mgr_write;
    logic [31:0] mgr_adr;
    logic [31:0] mgr_wdata;
    logic [3:0]  mgr_sel;
    logic [31:0] mgr_rdata = 32'd0;
    logic        mgr_busy = 1'b0;
    logic [7:0]  err_count;

    t04_mem_bridge #(.TIMEOUT(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mem_adr_start(mem_adr_start),
        .memory_size  (memory_size),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_adr      (cpu_adr),
        .cpu_wdata    (cpu_wdata),
        .cpu_sel      (cpu_sel),
        .cpu_rdata    (cpu_rdata),
        .cpu_busy     (cpu_busy),
        .cpu_adr_err  (cpu_adr_err),
        .mgr_read     (mgr_read),
        .mgr_write    (mgr_write),
        .mgr_adr      (mgr_adr),
        .mgr_wdata    (mgr_wdata),
        .mgr_sel      (mgr_sel),
        .mgr_rdata    (mgr_rdata),
        .mgr_busy     (mgr_busy),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic [7:0]  errc;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_strb = 0;
    logic [31:0] exp_rd = 32'd0;
    logic [7:0]  exp_err = 8'd0;
    int          mgr_lat = 0;
    bit          mgr_hang = 1'b0;
    int          mcnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Manager model: busy for mgr_lat negedges after a strobe, or forever when hung.
    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
        end else if (mgr_read || mgr_write) begin
            mcnt = mgr_hang ? 1 : mgr_lat;
        end else if (mcnt > 0 && !mgr_hang) begin
            mcnt--;
        end
        mgr_busy = (mcnt > 0);
    end

    task automatic take(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == K_RD || kind == K_WR) begin
                chk("mgr_adr", mgr_adr, e.adr);
                chk("mgr_wdata", mgr_wdata, e.wdata);
                chk("mgr_sel", 32'(mgr_sel), 32'(e.sel));
            end else if (kind == K_DONE) begin
                chk("done_rdata", cpu_rdata, e.rdata);
            end else begin
                chk("err_count_in_err", 32'(err_count), 32'(e.errc));
                chk("err_rdata_kept", cpu_rdata, e.rdata);
                if (e.gap >= 0) chk("timeout_gap", 32'(cyc - last_strb), 32'(e.gap));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mgr_read && mgr_write) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_overlap: got rd=1 wr=1 expected one (cycle %0d)", cyc);
            end
            if (mgr_read || mgr_write) begin
                last_strb = cyc;
                take(mgr_write ? K_WR : K_RD);
            end else if (cpu_adr_err) begin
                take(K_ERR);
            end else if ((cpu_read || cpu_write) && !cpu_busy) begin
                take(K_DONE);
            end
        end
    end

    function automatic void push(input int kind, input logic [31:0] adr, input logic [31:0] wd,
                                 input logic [3:0] sel, input logic [31:0] rd,
                                 input logic [7:0] ec, input int gap);
        exp_t e;
        e.kind = kind; e.adr = adr; e.wdata = wd; e.sel = sel;
        e.rdata = rd; e.errc = ec; e.gap = gap;
        sb.push_back(e);
    endfunction

    function automatic void err_push(input int gap);
        push(K_ERR, 32'd0, 32'd0, 4'd0, exp_rd, exp_err, gap);
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endfunction

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] sel);
        int n;
        @(posedge clk); #1;
        cpu_read = rd; cpu_write = wr; cpu_adr = adr; cpu_wdata = wd; cpu_sel = sel;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (cpu_busy && n < 400);
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: got busy after %0d cycles expected completion", n);
        end
        @(negedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic xfer(input bit rd, input logic [31:0] adr, input logic [31:0] exp_adr,
                        input logic [31:0] wd, input logic [3:0] sel, input int lat,
                        input logic [31:0] rdv);
        mgr_lat = lat;
        mgr_rdata = rdv;
        push(rd ? K_RD : K_WR, exp_adr, wd, sel, 32'd0, 8'd0, -1);
        if (rd) exp_rd = rdv;
        push(K_DONE, 32'd0, 32'd0, 4'd0, exp_rd, 8'd0, -1);
        do_req(rd, !rd, adr, wd, sel);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(cpu_busy), 32'd1);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_adr_err", 32'(cpu_adr_err), 32'd0);
        chk("rst_strobes", 32'({mgr_read, mgr_write}), 32'd0);
        chk("rst_mgr_adr", mgr_adr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy_after_rst", 32'(cpu_busy), 32'd0);

        // Directed transfers against the 0x3300_0000 / 0x400 window.
        xfer(1'b1, 32'h10,  32'h3300_0010, 32'h0,         4'hF, 3, 32'hDEAD_BEEF);
        mgr_rdata = 32'h0BAD_F00D;
        xfer(1'b0, 32'h3FC, 32'h3300_03FC, 32'h1234_5678, 4'hF, 2, 32'h0BAD_F00D);
        xfer(1'b1, 32'h20,  32'h3300_0020, 32'hAAAA_5555, 4'h3, 0, 32'hCAFE_F00D);
        mem_adr_start = 32'hFFFF_FFF0;
        xfer(1'b0, 32'h20,  32'h0000_0010, 32'h0F0F_0F0F, 4'h5, 1, 32'h1111_1111);
        mem_adr_start = 32'h3300_0000;

        err_push(-1);
        do_req(1'b1, 1'b0, 32'h3FD, 32'h0, 4'hF);
        err_push(-1);
        do_req(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 4'hF);
        err_push(-1);
        do_req(1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        chk("err_count_after_3", 32'(err_count), 32'd3);

        @(posedge clk); #1;
        en = 1'b0; cpu_read = 1'b1; cpu_adr = 32'h10;
        repeat (4) begin
            @(negedge clk);
            chk("busy_when_disabled", 32'(cpu_busy), 32'd1);
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; en = 1'b1;

        // Hung manager: 255 WAIT cycles then ERR, one cycle after the last WAIT.
        mgr_hang = 1'b1;
        push(K_RD, 32'h3300_0040, 32'h0, 4'hF, 32'd0, 8'd0, -1);
        err_push(256);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        mgr_hang = 1'b0;
        @(negedge clk);
        chk("idle_after_timeout", 32'(cpu_busy), 32'd0);
        chk("err_count_after_timeout", 32'(err_count), 32'd4);

        // Reset in the middle of WAIT.
        mgr_hang = 1'b1;
        push(K_RD, 32'h3300_0080, 32'h0, 4'hF, 32'd0, 8'd0, -1);
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_adr = 32'h80; cpu_wdata = 32'h0; cpu_sel = 4'hF;
        n = 0;
        while (!mgr_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            n_cmp++;
            n_bad++;
            $display("FAIL midwait_strobe: got no strobe expected mgr_read");
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(cpu_busy), 32'd1);
        chk("midrst_strobes", 32'({mgr_read, mgr_write}), 32'd0);
        chk("midrst_mgr_adr", mgr_adr, 32'd0);
        chk("midrst_mgr_wdata", mgr_wdata, 32'd0);
        chk("midrst_mgr_sel", 32'(mgr_sel), 32'd0);
        chk("midrst_rdata", cpu_rdata, 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        cpu_read = 1'b0; mgr_hang = 1'b0;
        exp_rd = 32'd0; exp_err = 8'd0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(cpu_busy), 32'd0);
        end

        // Saturation: 300 rejected requests.
        for (int i = 0; i < 300; i++) begin
            err_push(-1);
            do_req(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        end
        @(negedge clk);
        chk("err_count_saturated", 32'(err_count), 32'd255);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish by 400000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/t04_mem_bridge.md
T04_MEM_BRIDGE -- requirements
Module: t04_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for the manager to finish one transaction.
REQ-002 SHALL have ports in this order; every port is synchronous to clk:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  chip enable; low blocks new requests.
- mem_adr_start  in  32  base byte address of the CPU window.
- memory_size  in  32  window size in bytes.
- cpu_read  in  1  CPU read request (level).
- cpu_write  in  1  CPU write request (level).
- cpu_adr  in  32  CPU byte offset within the window.
- cpu_wdata  in  32  write data.
- cpu_sel  in  4  byte selects.
- cpu_rdata  out  32  read data returned to the CPU.
- cpu_busy  out  1  CPU must hold its request while this is high.
- cpu_adr_err  out  1  one-cycle pulse when a request is rejected.
- mgr_read  out  1  one-cycle read strobe to the wishbone manager.
- mgr_write  out  1  one-cycle write strobe to the wishbone manager.
- mgr_adr  out  32  absolute address.
- mgr_wdata  out  32  write data to the manager.
- mgr_sel  out  4  byte selects to the manager.
- mgr_rdata  in  32  read data from the manager.
- mgr_busy  in  1  manager transaction in progress.
- err_count  out  8  saturating count of rejected and timed-out requests.

Function
REQ-003 SHALL implement the FSM states IDLE, ISSUE, WAIT, DONE and ERR.
REQ-004 In IDLE with en=1 and exactly one of cpu_read/cpu_write high, the block SHALL latch cpu_adr, cpu_wdata, cpu_sel and the direction.
- In the same cycle it SHALL run the bounds check.
REQ-005 Bounds check: the request is legal when cpu_adr + 4 <= memory_size.
- The sum is computed in 33 bits, so no wrap is possible.
- Legal -> ISSUE; illegal -> ERR.
REQ-006 In IDLE, cpu_read=cpu_write=1 SHALL go to ERR; neither high SHALL stay in IDLE.
REQ-007 ISSUE SHALL last exactly one cycle.
- mgr_read or mgr_write is high for that cycle only, matching the latched direction.
- mgr_adr = latched cpu_adr + mem_adr_start, mod 2^32.
- Next state: WAIT.
REQ-008 mgr_adr, mgr_wdata and mgr_sel SHALL hold their latched values from ISSUE until the FSM leaves WAIT.
REQ-009 WAIT SHALL set a seen_busy flag when mgr_busy=1.
- WAIT -> DONE when seen_busy=1 and mgr_busy=0.
- Exception: a manager finishing within the ISSUE cycle (mgr_busy never observed high) SHALL not stall the FSM. After one full WAIT cycle with mgr_busy=0 and seen_busy=0, WAIT -> DONE.
REQ-010 WAIT SHALL run a cycle counter.
- When the counter reaches TIMEOUT with mgr_busy still 1, WAIT -> ERR.
- On that timeout cpu_rdata is unchanged.
REQ-011 On entry to DONE after a read, cpu_rdata SHALL capture mgr_rdata.
- cpu_rdata holds that value until the next completed read.
- Writes never modify cpu_rdata.
REQ-012 DONE and ERR SHALL each last one cycle and then return to IDLE.
REQ-013 cpu_busy SHALL be 1 in ISSUE and WAIT, 0 in DONE and ERR, and 1 whenever en=0.
- In IDLE it is 1 from the cycle a request is latched.
- In IDLE it is 0 only when no request is pending.
REQ-014 Handshake: the CPU sees the request complete in the first cycle cpu_busy=0 after it asserted the request.
- The CPU SHALL deassert the request in that cycle.
- A request still held in the following IDLE cycle is treated as a new request.
REQ-015 cpu_adr_err SHALL be 1 only in the ERR cycle.
REQ-016 err_count SHALL increment by 1 per ERR cycle and saturate at 255.
REQ-017 en=0 SHALL block new requests in IDLE.
- A transaction already past IDLE completes normally; the manager is never abandoned mid-transfer.
REQ-018 mgr_read and mgr_write SHALL never be high at the same time.
- Each SHALL be high for at most one cycle per transaction.

Reset
REQ-019 With rst=1 at a clock edge, the block SHALL take these values:
- State: IDLE.
- Outputs: cpu_rdata=0, cpu_busy=1, cpu_adr_err=0, mgr_read=0, mgr_write=0, mgr_adr=0, mgr_wdata=0, mgr_sel=0, err_count=0.
- Internal: seen_busy and the timeout counter cleared.
REQ-020 rst asserted mid-transaction SHALL abort to IDLE on that edge, with no further strobe issued.
REQ-021 The first cycle after rst deasserts SHALL be IDLE, with cpu_busy=0 when no request is present.

Verification
REQ-022 Read: mem_adr_start=0x3300_0000, memory_size=0x400, cpu_read with cpu_adr=0x10.
- Response: one-cycle mgr_read with mgr_adr=0x3300_0010.
- Manager busy 3 cycles, mgr_rdata=0xDEAD_BEEF.
- Then DONE: cpu_busy=0 and cpu_rdata=0xDEAD_BEEF.
REQ-023 Write: cpu_write with cpu_adr=0x3FC, cpu_wdata=0x1234_5678, cpu_sel=0xF.
- Response: one-cycle mgr_write carrying those values.
- cpu_rdata unchanged.
REQ-024 Out of bounds: cpu_adr=0x3FD with memory_size=0x400.
- Response: no mgr strobe, cpu_adr_err pulses for one cycle, err_count goes 0 -> 1.
REQ-025 Timeout: mgr_busy held high indefinitely after ISSUE.
- Response: ERR after 255 WAIT cycles, err_count increments, FSM back in IDLE.
REQ-026 Protocol edges:
- cpu_read=cpu_write=1 -> ERR.
- en=0 with cpu_read=1 -> no strobe and cpu_busy=1.
- 300 forced errors -> err_count=255.
REQ-027 Reset mid-WAIT: assert rst during WAIT.
- Response: IDLE next cycle, all outputs at reset values, no further strobe.
